// File: rtl/athos_premul.sv
// -----------------------------------------------------------------------------
// athos_premul
// Pipelined signed multiplier that feeds the Montgomery reduction stage with
// its raw product (lo_o -> rs1_0, hi_o -> rs2_0).
//   mode 0 (Kyber)     : signed(a_i[15:0]) * signed(b_i[15:0]), sign-extended
//                        into {hi_o, lo_o}.
//   mode 1 (Dilithium) : signed(a_i) * signed(b_i), full 64-bit {hi_o, lo_o}.
//
// Parameters
//   STAGES  register stages from accepted input to output register (1..4)
//   MODE_W  width of the mode field
//
// Ports
//   clk_i, rst_i       clock, synchronous active-high reset
//   valid_i / ready_o  input handshake (operands a_i, b_i, mode_i)
//   valid_o / ready_i  output handshake (product lo_o, hi_o, mode_o)
//   perf_prod_o        output transfer counter   (ATHOS_PREMUL_PERF_EN only)
//   perf_stall_o       stalled cycle counter     (ATHOS_PREMUL_PERF_EN only)
//
// Optional feature macro: ATHOS_PREMUL_PERF_EN
// -----------------------------------------------------------------------------
module athos_premul #(
  parameter int unsigned STAGES = 2,
  parameter int unsigned MODE_W = 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [MODE_W-1:0] mode_i,
  input  logic [31:0]       a_i,
  input  logic [31:0]       b_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [MODE_W-1:0] mode_o,
  output logic [31:0]       lo_o,
  output logic [31:0]       hi_o
`ifdef ATHOS_PREMUL_PERF_EN
  ,
  output logic [31:0]       perf_prod_o,
  output logic [31:0]       perf_stall_o
`endif
);

  // Stage 1 holds the raw operands when there is room for it; the multiply
  // lands in stage 2 and later stages just delay the product. With a single
  // stage the product is registered straight from the inputs.
  localparam int unsigned MUL_STAGE = (STAGES == 1) ? 1 : 2;

  logic              stall;
  logic              vld_q  [1:STAGES];
  logic [MODE_W-1:0] mode_q [1:STAGES];
  logic [63:0]       data_q [1:STAGES];

  // Operand pair travels packed as {a, b}; result is {hi, lo}.
  // Kyber operands are sign-extended from 16 bits, which makes the 64-bit
  // product equal to the sign-extended 32-bit Kyber product.
  function automatic logic [63:0] premul(input logic [MODE_W-1:0] m,
                                         input logic [63:0]       ab);
    logic signed [63:0] ax;
    logic signed [63:0] bx;
    logic signed [63:0] p;
    if (m == '0) begin
      ax = {{48{ab[47]}}, ab[47:32]};
      bx = {{48{ab[15]}}, ab[15:0]};
    end else begin
      ax = {{32{ab[63]}}, ab[63:32]};
      bx = {{32{ab[31]}}, ab[31:0]};
    end
    p = ax * bx;
    return p;
  endfunction

  assign valid_o = vld_q[STAGES];
  assign mode_o  = mode_q[STAGES];
  assign lo_o    = data_q[STAGES][31:0];
  assign hi_o    = data_q[STAGES][63:32];

  // Global stall: only a full, blocked output register freezes the pipe.
  assign stall   = valid_o && !ready_i;
  assign ready_o = !stall;

  for (genvar s = 1; s <= STAGES; s++) begin : g_stage
    logic              v_in;
    logic [MODE_W-1:0] m_in;
    logic [63:0]       d_in;
    logic [63:0]       d_nxt;

    if (s == 1) begin : g_src
      assign v_in = valid_i;
      assign m_in = mode_i;
      assign d_in = {a_i, b_i};
    end else begin : g_src
      assign v_in = vld_q[s-1];
      assign m_in = mode_q[s-1];
      assign d_in = data_q[s-1];
    end

    assign d_nxt = (s == MUL_STAGE) ? premul(m_in, d_in) : d_in;

    // Payload only loads behind a valid entry, so the output register keeps
    // its last product while bubbles pass through.
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        vld_q[s]  <= 1'b0;
        mode_q[s] <= '0;
        data_q[s] <= '0;
      end else if (!stall) begin
        vld_q[s] <= v_in;
        if (v_in) begin
          mode_q[s] <= m_in;
          data_q[s] <= d_nxt;
        end
      end
    end
  end

`ifdef ATHOS_PREMUL_PERF_EN
  logic [31:0] prod_cnt_q;
  logic [31:0] stall_cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      prod_cnt_q  <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (valid_o && ready_i) prod_cnt_q  <= prod_cnt_q + 32'd1;
      if (stall)              stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign perf_prod_o  = prod_cnt_q;
  assign perf_stall_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_athos_premul.sv
// -----------------------------------------------------------------------------
// tb_athos_premul
// Self-checking bench for athos_premul (default STAGES=2, MODE_W=1).
// Expected products come from plain signed arithmetic on the operands; a
// queue of expected items is compared against the queue of popped products.
// Perf counter checks are compiled in when ATHOS_PREMUL_PERF_EN is defined.
// -----------------------------------------------------------------------------
module tb_athos_premul;

  localparam int STAGES = 2;

  typedef struct {
    logic        mode;
    logic [31:0] lo;
    logic [31:0] hi;
    int          cyc;
  } item_t;

  logic        clk;
  logic        rst;
  logic        valid_i;
  logic        ready_o;
  logic [0:0]  mode_i;
  logic [31:0] a_in;
  logic [31:0] b_in;
  logic        valid_o;
  logic        ready_i;
  logic [0:0]  mode_o;
  logic [31:0] lo;
  logic [31:0] hi;
`ifdef ATHOS_PREMUL_PERF_EN
  logic [31:0] perf_prod;
  logic [31:0] perf_stall;
`endif

  int    errors = 0;
  int    checks = 0;
  int    cyc    = 0;
  int    prod_seen  = 0;
  int    stall_seen = 0;
  bit    last_fire_in = 0;
  item_t exp_q[$];
  item_t got_q[$];

  athos_premul #(
    .STAGES (STAGES),
    .MODE_W (1)
  ) dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .mode_i  (mode_i),
    .a_i     (a_in),
    .b_i     (b_in),
    .valid_o (valid_o),
    .ready_i (ready_i),
    .mode_o  (mode_o),
    .lo_o    (lo),
    .hi_o    (hi)
`ifdef ATHOS_PREMUL_PERF_EN
    ,
    .perf_prod_o  (perf_prod),
    .perf_stall_o (perf_stall)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference: product from ordinary signed integer arithmetic.
  function automatic item_t model(input logic m, input logic [31:0] a, input logic [31:0] b);
    item_t       r;
    longint      p;
    logic [15:0] al;
    logic [15:0] bl;
    al = a[15:0];
    bl = b[15:0];
    if (m) p = longint'($signed(a)) * longint'($signed(b));
    else   p = longint'($signed(al)) * longint'($signed(bl));
    r.mode = m;
    r.lo   = p[31:0];
    r.hi   = p[63:32];
    r.cyc  = 0;
    return r;
  endfunction

  // Advance one clock; log input/output transfers seen at the negedge.
  task automatic cycle();
    item_t it;
    @(negedge clk);
    last_fire_in = 1'b0;
    if (!rst && valid_i && ready_o) begin
      it = model(mode_i[0], a_in, b_in);
      it.cyc = cyc;
      exp_q.push_back(it);
      last_fire_in = 1'b1;
    end
    if (!rst && valid_o && ready_i) begin
      it.mode = mode_o[0];
      it.lo   = lo;
      it.hi   = hi;
      it.cyc  = cyc;
      got_q.push_back(it);
      prod_seen++;
    end
    if (!rst && valid_o && !ready_i) stall_seen++;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic drain();
    valid_i = 1'b0;
    ready_i = 1'b1;
    for (int k = 0; k < 40 && got_q.size() < exp_q.size(); k++) cycle();
    for (int k = 0; k < STAGES + 2; k++) cycle();
  endtask

  task automatic test_reset();
    rst = 1'b1; valid_i = 1'b0; ready_i = 1'b0;
    mode_i = '0; a_in = '0; b_in = '0;
    for (int k = 0; k < 3; k++) cycle();
    rst = 1'b0;
    #1;
    checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", valid_o); end
    checks++; if (lo !== 32'h0) begin errors++; $display("FAIL reset_lo: got %h expected 00000000", lo); end
    checks++; if (hi !== 32'h0) begin errors++; $display("FAIL reset_hi: got %h expected 00000000", hi); end
    checks++; if (mode_o !== 1'b0) begin errors++; $display("FAIL reset_mode: got %b expected 0", mode_o); end
    checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", ready_o); end
`ifdef ATHOS_PREMUL_PERF_EN
    checks++; if (perf_prod !== 32'd0) begin errors++; $display("FAIL reset_perf_prod: got %0d expected 0", perf_prod); end
    checks++; if (perf_stall !== 32'd0) begin errors++; $display("FAIL reset_perf_stall: got %0d expected 0", perf_stall); end
`endif
    exp_q.delete(); got_q.delete();
    prod_seen = 0; stall_seen = 0;
  endtask

  task automatic test_directed();
    logic        tm [5];
    logic [31:0] ta [5];
    logic [31:0] tb [5];
    logic [31:0] tlo[5];
    logic [31:0] thi[5];
    tm  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    ta  = '{32'd1000, 32'hABCDFFFE, 32'h1234FFFE, 32'd65536, 32'hFFFFFFFF};
    tb  = '{32'd3000, 32'd3,        32'h7FFF0003, 32'd65536, 32'hFFFFFFFF};
    tlo = '{32'h002DC6C0, 32'hFFFFFFFA, 32'hFFFFFFFA, 32'h00000000, 32'h00000001};
    thi = '{32'h00000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 32'h00000000};
    exp_q.delete(); got_q.delete();
    ready_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      valid_i = 1'b1; mode_i[0] = tm[i]; a_in = ta[i]; b_in = tb[i];
      cycle();
    end
    drain();
    checks++;
    if (got_q.size() !== 5) begin
      errors++; $display("FAIL directed_count: got %0d expected 5", got_q.size());
    end
    for (int i = 0; i < 5 && i < got_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (got_q[i].lo !== tlo[i] || got_q[i].hi !== thi[i] || got_q[i].mode !== tm[i]) begin
        errors++;
        $display("FAIL directed_%0d: got hi=%h lo=%h mode=%b expected hi=%h lo=%h mode=%b",
                 i, got_q[i].hi, got_q[i].lo, got_q[i].mode, thi[i], tlo[i], tm[i]);
      end
      checks++;
      if (got_q[i].cyc - exp_q[i].cyc !== STAGES) begin
        errors++;
        $display("FAIL directed_latency_%0d: got %0d expected %0d", i, got_q[i].cyc - exp_q[i].cyc, STAGES);
      end
    end
  endtask

  task automatic test_back_to_back();
    exp_q.delete(); got_q.delete();
    ready_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      valid_i = 1'b1; mode_i[0] = i[0]; a_in = $urandom; b_in = $urandom;
      cycle();
    end
    drain();
    checks++;
    if (got_q.size() !== 8) begin
      errors++; $display("FAIL b2b_count: got %0d expected 8", got_q.size());
    end
    for (int i = 0; i < 8 && i < got_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (got_q[i].lo !== exp_q[i].lo || got_q[i].hi !== exp_q[i].hi || got_q[i].mode !== exp_q[i].mode) begin
        errors++;
        $display("FAIL b2b_%0d: got hi=%h lo=%h mode=%b expected hi=%h lo=%h mode=%b",
                 i, got_q[i].hi, got_q[i].lo, got_q[i].mode, exp_q[i].hi, exp_q[i].lo, exp_q[i].mode);
      end
      checks++;
      if (got_q[i].cyc - exp_q[i].cyc !== STAGES) begin
        errors++;
        $display("FAIL b2b_latency_%0d: got %0d expected %0d", i, got_q[i].cyc - exp_q[i].cyc, STAGES);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] s_lo;
    logic [31:0] s_hi;
    logic        s_mode;
`ifdef ATHOS_PREMUL_PERF_EN
    logic [31:0] stall_ref;
`endif
    exp_q.delete(); got_q.delete();
    ready_i = 1'b1;
    valid_i = 1'b1; mode_i[0] = 1'b1; a_in = $urandom; b_in = $urandom;
    for (int k = 0; k < 10 && !valid_o; k++) begin
      cycle();
      if (last_fire_in) begin mode_i[0] = ~mode_i[0]; a_in = $urandom; b_in = $urandom; end
    end
    checks++;
    if (valid_o !== 1'b1) begin errors++; $display("FAIL bp_fill_timeout: got valid_o=%b expected 1", valid_o); end
    ready_i = 1'b0;
    #1;
    s_lo = lo; s_hi = hi; s_mode = mode_o[0];
`ifdef ATHOS_PREMUL_PERF_EN
    stall_ref = perf_stall;
`endif
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (ready_o !== 1'b0) begin errors++; $display("FAIL bp_ready_%0d: got %b expected 0", k, ready_o); end
      cycle();
      checks++;
      if (valid_o !== 1'b1 || lo !== s_lo || hi !== s_hi || mode_o[0] !== s_mode) begin
        errors++;
        $display("FAIL bp_hold_%0d: got v=%b hi=%h lo=%h mode=%b expected v=1 hi=%h lo=%h mode=%b",
                 k, valid_o, hi, lo, mode_o[0], s_hi, s_lo, s_mode);
      end
    end
`ifdef ATHOS_PREMUL_PERF_EN
    checks++;
    if (perf_stall - stall_ref !== 32'd5) begin
      errors++; $display("FAIL bp_perf_stall: got delta %0d expected 5", perf_stall - stall_ref);
    end
`endif
    ready_i = 1'b1;
    cycle();
    drain();
    checks++;
    if (got_q.size() !== exp_q.size()) begin
      errors++; $display("FAIL bp_count: got %0d expected %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (got_q[i].lo !== exp_q[i].lo || got_q[i].hi !== exp_q[i].hi || got_q[i].mode !== exp_q[i].mode) begin
        errors++;
        $display("FAIL bp_item_%0d: got hi=%h lo=%h expected hi=%h lo=%h",
                 i, got_q[i].hi, got_q[i].lo, exp_q[i].hi, exp_q[i].lo);
      end
    end
  endtask

  task automatic test_random();
    bit          stalled;
    logic [31:0] s_lo;
    logic [31:0] s_hi;
    logic        s_mode;
    int          bad_hold;
    int          bad_ready;
    exp_q.delete(); got_q.delete();
    valid_i = 1'b0; last_fire_in = 1'b0;
    bad_hold = 0; bad_ready = 0;
    for (int k = 0; k < 300; k++) begin
      if (!valid_i || last_fire_in) begin
        valid_i = ($urandom_range(0, 3) != 0);
        mode_i[0] = $urandom_range(0, 1);
        a_in = $urandom; b_in = $urandom;
      end
      ready_i = ($urandom_range(0, 99) < 65);
      #1;
      stalled = valid_o && !ready_i;
      if (ready_o !== !stalled) bad_ready++;
      s_lo = lo; s_hi = hi; s_mode = mode_o[0];
      cycle();
      if (stalled && (valid_o !== 1'b1 || lo !== s_lo || hi !== s_hi || mode_o[0] !== s_mode)) bad_hold++;
    end
    checks++;
    if (bad_ready !== 0) begin errors++; $display("FAIL rand_ready: got %0d bad cycles expected 0", bad_ready); end
    checks++;
    if (bad_hold !== 0) begin errors++; $display("FAIL rand_hold: got %0d bad cycles expected 0", bad_hold); end
    drain();
    checks++;
    if (got_q.size() !== exp_q.size()) begin
      errors++; $display("FAIL rand_count: got %0d expected %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (got_q[i].lo !== exp_q[i].lo || got_q[i].hi !== exp_q[i].hi || got_q[i].mode !== exp_q[i].mode) begin
        errors++;
        $display("FAIL rand_item_%0d: got hi=%h lo=%h mode=%b expected hi=%h lo=%h mode=%b",
                 i, got_q[i].hi, got_q[i].lo, got_q[i].mode, exp_q[i].hi, exp_q[i].lo, exp_q[i].mode);
      end
    end
`ifdef ATHOS_PREMUL_PERF_EN
    checks++;
    if (perf_prod !== 32'(prod_seen)) begin
      errors++; $display("FAIL rand_perf_prod: got %0d expected %0d", perf_prod, prod_seen);
    end
    checks++;
    if (perf_stall !== 32'(stall_seen)) begin
      errors++; $display("FAIL rand_perf_stall: got %0d expected %0d", perf_stall, stall_seen);
    end
`endif
  endtask

  task automatic test_reset_midflight();
    ready_i = 1'b1;
    for (int i = 0; i < 2; i++) begin
      valid_i = 1'b1; mode_i[0] = i[0]; a_in = $urandom; b_in = $urandom;
      cycle();
    end
    valid_i = 1'b0;
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    ready_i = 1'b0;
    #1;
    checks++;
    if (valid_o !== 1'b0) begin errors++; $display("FAIL midrst_valid: got %b expected 0", valid_o); end
    checks++;
    if (ready_o !== 1'b1) begin errors++; $display("FAIL midrst_ready: got %b expected 1", ready_o); end
`ifdef ATHOS_PREMUL_PERF_EN
    checks++;
    if (perf_prod !== 32'd0) begin errors++; $display("FAIL midrst_perf_prod: got %0d expected 0", perf_prod); end
`endif
    exp_q.delete(); got_q.delete();
    prod_seen = 0; stall_seen = 0;
    ready_i = 1'b1;
    for (int k = 0; k < 10; k++) cycle();
    checks++;
    if (got_q.size() !== 0) begin
      errors++; $display("FAIL midrst_stale: got %0d products expected 0", got_q.size());
    end
  endtask

  initial begin
    rst = 1'b1; valid_i = 1'b0; ready_i = 1'b0;
    mode_i = '0; a_in = '0; b_in = '0;
    @(posedge clk);
    #1;
    test_reset();
    test_directed();
    test_back_to_back();
    test_backpressure();
    test_random();
    test_reset_midflight();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/athos_premul.md
Name: athos_premul

Overview:
- Pipelined signed multiplier that sits directly upstream of the Montgomery reduction stage.
- Produces the raw product that the reduction stage consumes as its rs1_0/rs2_0 operand pair:
  - Kyber: 16x16 signed multiply, 32-bit product.
  - Dilithium: 32x32 signed multiply, 64-bit product.
- Valid/ready handshake on both sides; the whole pipeline stalls on output back-pressure.

Parameters:
- STAGES, 2, number of register stages from accepted input to output register (legal range 1..4).
- MODE_W, 1, width of mode_i.

Ports:
- clk_i  input  1  clock.
- rst_i  input  1  synchronous reset, active-high.
- valid_i  input  1  input operands valid.
- ready_o  output  1  block can accept an operand pair this cycle.
- mode_i  input  MODE_W  0 = Kyber, 1 = Dilithium; sampled together with operands.
- a_i  input  32  operand A (signed).
- b_i  input  32  operand B (signed).
- valid_o  output  1  product valid.
- ready_i  input  1  downstream reduction stage accepts the product.
- mode_o  output  MODE_W  mode travelling with the product.
- lo_o  output  32  product bits [31:0]; drives rs1_0 downstream.
- hi_o  output  32  product bits [63:32]; drives rs2_0 downstream.

Behaviour:
- Clock and reset:
  - One clock, clk_i.
  - Reset is synchronous and active-high on rst_i.
- Reset:
  - All stage valid bits clear.
  - valid_o=0, lo_o=0, hi_o=0, mode_o=0.
  - ready_o=1 on the first cycle after reset deasserts.
- Handshakes:
  - Input transfer when valid_i && ready_o.
  - Output transfer when valid_o && ready_i.
- Stall:
  - stall = valid_o && !ready_i.
  - When stall is true, every stage register holds its value.
  - When stall is false, every stage advances by one position.
  - ready_o = !stall, purely combinational from the output valid and ready_i.
  - No bubble collapsing: empty stages do not compress while stalled.
- Latency and throughput:
  - An operand pair accepted in cycle N appears on valid_o in cycle N+STAGES, provided no stall occurs.
  - Throughput is 1 product per cycle.
- Kyber arithmetic (mode 0):
  - Product p = signed(a_i[15:0]) * signed(b_i[15:0]); a_i[31:16] and b_i[31:16] are ignored.
  - lo_o = p (32-bit).
  - hi_o = {32{p[31]}}, i.e. sign extension.
- Dilithium arithmetic (mode 1):
  - Product p = signed(a_i) * signed(b_i), full 64-bit result.
  - {hi_o, lo_o} = p.
- Mode mixing: mode is carried per entry, so back-to-back items of different modes are legal with no pipeline drain.
- Stage partitioning:
  - Stage 1 registers the operands and mode.
  - Remaining stages register partial products and their sum; the partitioning is free.
  - Any partitioning is acceptable provided latency is exactly STAGES.
- Output hold:
  - While valid_o=1 and ready_i=0, lo_o, hi_o and mode_o remain stable.
  - When valid_o=0, lo_o and hi_o retain their last values; downstream ignores them.
- Simultaneous events:
  - Input accept and output pop in the same cycle are both performed.
  - Occupancy is unchanged in that case.
- Reset mid-operation:
  - rst_i=1 in any cycle drops all in-flight entries at the next edge.
  - No partial product is emitted afterwards.
- valid_i with ready_o=0: operands are not captured; the upstream block must hold them.

Optional Feature:
- Macro: ATHOS_PREMUL_PERF_EN.
- When defined:
  - Adds output perf_prod_o (32 bits), counting output transfers.
  - Adds output perf_stall_o (32 bits), counting cycles where stall=1.
  - Both counters are cleared by rst_i and wrap modulo 2^32.
- When undefined: the two ports and counters are absent; all other behaviour is identical.

Test Plan:
- Kyber, a_i=1000, b_i=3000, ready_i=1 -> after STAGES cycles: lo_o=0x002DC6C0, hi_o=0x00000000, mode_o=0.
- Kyber, a_i=0xABCDFFFE (low half = -2), b_i=3 -> lo_o=0xFFFFFFFA, hi_o=0xFFFFFFFF; upper operand bits have no effect.
- Dilithium, a_i=65536, b_i=65536 -> hi_o=0x00000001, lo_o=0x00000000. Dilithium, a_i=b_i=0xFFFFFFFF (-1) -> hi_o=0, lo_o=1.
- Back-to-back alternating modes, 8 pairs, ready_i=1 -> 8 products in order, one per cycle, each mode_o matching its input.
- Back-pressure: hold ready_i=0 for 5 cycles while valid_o=1 -> ready_o=0, outputs stable, nothing lost or duplicated after release. With ATHOS_PREMUL_PERF_EN, perf_stall_o advances by 5.
- rst_i=1 with 2 entries in flight -> next cycle valid_o=0 and ready_o=1; no stale product appears afterwards.
